// File: rtl/led_share_arbiter_pkg.sv
// Shared types and helpers for the LED bank arbiter.
package led_share_pkg;

    // Arbiter top-level state.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // All LEDs dark on an active-low bank; callers slice to their bank width.
    localparam logic [31:0] LED_OFF = '1;

    // One-hot vector with bit idx set; callers truncate to their requester count (max 8).
    function automatic logic [7:0] onehot(input int unsigned idx);
        logic [7:0] v;
        v = 8'd1 << idx;
        return v;
    endfunction

endpackage

// File: rtl/led_share_arbiter_if.sv
// Requester-side bus of the LED arbiter: requests and patterns in, ownership and pins out.
interface led_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int LED_W = 6
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LED_W-1:0] req_data;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic [LED_W-1:0]       led;

    modport master (output req, output req_data, input grant, input busy, input led);
    modport slave  (input req, input req_data, output grant, output busy, output led);
endinterface

// File: rtl/led_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping around.
module rr_pick
    import led_share_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any
);

    // Search last+1, last+2, ... so the previous owner is considered last.
    always_comb begin
        winner_idx = '0;
        any        = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((int'(last) + k) % N_REQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                winner_idx = idx;
            end
        end
        winner = N_REQ'(onehot(int'(winner_idx)));
    end

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the shared active-low LED bank with a minimum display time per grant.
module led_share_arbiter
    import led_share_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int LED_W       = 6,
    parameter int HOLD_CYCLES = 2_700_000,
    parameter int CNT_W       = 24
) (
    input  logic            clk,
    input  logic            rst,
    led_share_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [IDX_W-1:0] last;
    logic [N_REQ-1:0] grant_q;
    logic [LED_W-1:0] led_q;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             others;
    logic             expired;
    logic [LED_W-1:0] owner_data;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (bus.req),
        .last       (last),
        .winner     (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // While granted, 'last' is the current owner, so grant_q masks it out of "others".
    assign owner_req  = bus.req[last];
    assign owner_data = bus.req_data[int'(last)*LED_W +: LED_W];
    assign others     = |(bus.req & ~grant_q);
    assign expired    = (hold_cnt == HOLD_LAST);

    // Arbitration state, hold timer and registered LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            hold_cnt <= '0;
            last     <= IDX_W'(N_REQ - 1);
            led_q    <= LED_OFF[LED_W-1:0];
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        grant_q  <= pick_oh;
                        hold_cnt <= '0;
                        last     <= pick_idx;
                    end
                end
                GRANT: begin
                    // Live pattern while the owner requests; frozen otherwise.
                    if (owner_req) begin
                        led_q <= ~owner_data;
                    end
                    if (expired) begin
                        if (others) begin
                            grant_q  <= pick_oh;
                            hold_cnt <= '0;
                            last     <= pick_idx;
                        end else if (!owner_req) begin
                            state   <= IDLE;
                            grant_q <= '0;
                            led_q   <= LED_OFF[LED_W-1:0];
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = |grant_q;
    assign bus.led   = led_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Directed and randomized checks of led_share_arbiter against a behavioural model.
module tb_led_share_arbiter;

    localparam int N    = 4;
    localparam int W    = 6;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_share_arbiter_if #(.N_REQ(N), .LED_W(W)) bus ();

    led_share_arbiter #(
        .N_REQ(N), .LED_W(W), .HOLD_CYCLES(HOLD), .CNT_W(24)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: owner index (-1 = idle), cycles spent in grant, led value, previous owner.
    int         m_owner = -1;
    int         m_age   = 0;
    int         m_last  = N - 1;
    logic [5:0] m_led   = 6'h3F;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_last  = N - 1;
        m_led   = 6'h3F;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [23:0] d);
        logic [3:0] mine;
        if (m_owner < 0) begin
            if (r != 4'd0) begin
                m_owner = pick(r, m_last);
                m_last  = m_owner;
                m_age   = 0;
            end
        end else begin
            if (r[m_owner]) m_led = ~d[m_owner*W +: W];
            if (m_age >= HOLD - 1) begin
                mine = 4'd1 << m_owner;
                if ((r & ~mine) != 4'd0) begin
                    m_owner = pick(r, m_last);
                    m_last  = m_owner;
                    m_age   = 0;
                end else if (!r[m_owner]) begin
                    m_owner = -1;
                    m_led   = 6'h3F;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'd0 : 4'(4'd1 << m_owner);
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
        chk("led", 32'(bus.led), 32'(m_led));
        chk("onehot0", 32'($onehot0(bus.grant)), 32'd1);
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, sample 1 ns later.
    task automatic cycle(input logic [3:0] r, input logic [23:0] d);
        @(negedge clk);
        bus.req      = r;
        bus.req_data = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_model();
    endtask

    initial begin
        logic [3:0]  rr;
        logic [23:0] dd;
        bus.req      = '0;
        bus.req_data = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_led", 32'(bus.led), 32'h3F);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // All requesting: owners 0,1,2,3,0 with 4 cycles each and no gap.
        for (int j = 0; j < 20; j++) begin
            cycle(4'b1111, 24'($urandom));
            chk("rr_order", 32'(bus.grant), 32'(4'd1 << ((j / 4) % 4)));
        end
        repeat (3) cycle(4'b0000, 24'd0);

        // Single request: grant one cycle later, pattern one cycle after that.
        cycle(4'b0100, 24'h15 << 12);
        chk("req2_grant", 32'(bus.grant), 32'h4);
        cycle(4'b0100, 24'h15 << 12);
        chk("req2_led", 32'(bus.led), 32'h2A);
        repeat (6) cycle(4'b0000, 24'd0);

        // Brief request: grant still lasts the full hold with the pattern frozen, then idle.
        cycle(4'b0010, 24'h3F << 6);
        cycle(4'b0010, 24'h3F << 6);
        chk("pulse_led", 32'(bus.led), 32'h00);
        for (int j = 0; j < 2; j++) begin
            cycle(4'b0000, 24'd0);
            chk("pulse_hold_grant", 32'(bus.grant), 32'h2);
            chk("pulse_frozen_led", 32'(bus.led), 32'h00);
        end
        cycle(4'b0000, 24'd0);
        chk("pulse_idle_grant", 32'(bus.grant), 32'h0);
        chk("pulse_idle_led", 32'(bus.led), 32'h3F);

        // Lone long request: no forced release; dropping it ends the grant on the next edge.
        for (int j = 0; j < 20; j++) begin
            cycle(4'b1000, 24'($urandom));
            chk("solo_grant", 32'(bus.grant), 32'h8);
        end
        cycle(4'b0000, 24'd0);
        chk("solo_drop_grant", 32'(bus.grant), 32'h0);
        chk("solo_drop_busy", 32'(bus.busy), 32'h0);

        // Expired owner drops on the same edge another rises: direct hand-over.
        repeat (4) cycle(4'b0001, 24'h2A);
        cycle(4'b0100, 24'h33 << 12);
        chk("handover_grant", 32'(bus.grant), 32'h4);
        chk("handover_busy", 32'(bus.busy), 32'h1);
        repeat (6) cycle(4'b0000, 24'd0);

        // Randomized traffic with sticky requests.
        rr = 4'd0;
        for (int j = 0; j < 400; j++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3) == 0) rr[b] = ~rr[b];
            end
            dd = 24'($urandom);
            cycle(rr, dd);
        end

        // Reset in the middle of a grant takes effect without a clock edge.
        repeat (2) cycle(4'b1000, 24'h0F << 18);
        rst = 1'b1;
        #2;
        chk("async_rst_grant", 32'(bus.grant), 32'd0);
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_led", 32'(bus.led), 32'h3F);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req = '0;
        repeat (3) cycle(4'b0001, 24'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
